// File: rtl/alt_vipitc_mode_bank_calc_if.sv
// Bus bundle between the control-port slave, the mode bank calculator and the IS2Vid timing generator.
// Carries bank writes, calculation requests, the frame boundary and the live timing set.
interface alt_vipitc_mode_bank_calc_if #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned MODE_BITS = 2
);
   logic                 wr_en;
   logic [MODE_BITS-1:0] wr_mode;
   logic [3:0]           wr_addr;
   logic [WIDTH-1:0]     wr_data;
   logic                 wr_err;
   logic                 calc_req;
   logic [MODE_BITS-1:0] calc_mode;
   logic                 calc_busy;
   logic                 frame_start;
   logic                 commit;
   logic [MODE_BITS-1:0] active_mode;
   logic                 interlaced;
   logic                 serial_output;
   logic [WIDTH-1:0]     h_total_minus_one;
   logic [WIDTH-1:0]     v_total_minus_one;
   logic [WIDTH-1:0]     ap_line_end;
   logic [WIDTH-1:0]     h_blank;
   logic [WIDTH-1:0]     sav;
   logic [WIDTH-1:0]     h_sync_start;
   logic [WIDTH-1:0]     h_sync_end;
   logic [WIDTH-1:0]     f2_v_start;
   logic [WIDTH-1:0]     f1_v_start;
   logic [WIDTH-1:0]     f1_v_end;
   logic [WIDTH-1:0]     f2_v_sync_start;
   logic [WIDTH-1:0]     f2_v_sync_end;
   logic [WIDTH-1:0]     f1_v_sync_start;
   logic [WIDTH-1:0]     f1_v_sync_end;

   modport master (
      output wr_en, wr_mode, wr_addr, wr_data, calc_req, calc_mode, frame_start,
      input  wr_err, calc_busy, commit, active_mode, interlaced, serial_output,
             h_total_minus_one, v_total_minus_one, ap_line_end, h_blank, sav,
             h_sync_start, h_sync_end, f2_v_start, f1_v_start, f1_v_end,
             f2_v_sync_start, f2_v_sync_end, f1_v_sync_start, f1_v_sync_end
   );

   modport slave (
      input  wr_en, wr_mode, wr_addr, wr_data, calc_req, calc_mode, frame_start,
      output wr_err, calc_busy, commit, active_mode, interlaced, serial_output,
             h_total_minus_one, v_total_minus_one, ap_line_end, h_blank, sav,
             h_sync_start, h_sync_end, f2_v_start, f1_v_start, f1_v_end,
             f2_v_sync_start, f2_v_sync_end, f1_v_sync_start, f1_v_sync_end
   );
endinterface

// File: rtl/alt_vipitc_mode_bank_calc.sv
// Stored video-mode bank with a sequential timing calculator sharing one adder/subtractor.
// Results are built in shadow registers and go live together on a frame boundary.
module alt_vipitc_mode_bank_calc #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NUM_MODES = 4,
   parameter int unsigned MODE_BITS = 2
) (
   input  logic clk,
   input  logic rst,
   alt_vipitc_mode_bank_calc_if.slave bus
);

   localparam int unsigned NUM_FIELDS = 16;
   localparam int unsigned STEP_BITS  = 4;
   localparam logic [STEP_BITS-1:0] LAST_STEP  = STEP_BITS'(NUM_FIELDS - 1);
   localparam logic [MODE_BITS:0]   MODE_LIMIT = (MODE_BITS + 1)'(NUM_MODES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] PEND = 2'd2;

   // Descriptor field indices
   localparam int unsigned F_FLAGS = 0,  F_SAMPLES = 1,  F_LINES_F0 = 2,  F_LINES_F1 = 3;
   localparam int unsigned F_H_FP  = 4,  F_H_SYNC  = 5,  F_H_BLANK  = 6,  F_V_FP     = 7;
   localparam int unsigned F_V_SYNC = 8, F_V_BLANK = 9,  F_V1_FP    = 10, F_V1_SYNC  = 11;
   localparam int unsigned F_V1_BLANK = 12, F_AP_LINE = 13, F_V1_RISE = 14, F_TRS = 15;

   // Shadow slot written by each calculation step (slot index == step number)
   localparam int unsigned S_VACT = 0,  S_F2_V_START = 1,  S_V_TOTAL = 2,  S_V_TOTAL_M1 = 3;
   localparam int unsigned S_AP_END = 4, S_H_TOTAL = 5,    S_H_TOTAL_M1 = 6, S_SAV = 7;
   localparam int unsigned S_HS_START = 8, S_HS_END = 9,   S_F1_V_START = 10, S_F1_V_END = 11;
   localparam int unsigned S_F2_VS_START = 12, S_F2_VS_END = 13, S_F1_VS_START = 14, S_F1_VS_END = 15;

   logic [WIDTH-1:0]     bank [NUM_MODES][NUM_FIELDS];
   logic [WIDTH-1:0]     sh   [NUM_FIELDS];
   logic [WIDTH-1:0]     fld  [NUM_FIELDS];
   logic                 sh_il, sh_ser;
   logic [WIDTH-1:0]     sh_h_blank;
   logic [1:0]           state, state_nxt;
   logic [STEP_BITS-1:0] step;
   logic [MODE_BITS-1:0] mode_q;
   logic                 start_c, commit_c, calc_ok_c, wr_drop_c, il_c;
   logic [WIDTH-1:0]     op_a, op_b, alu_c;
   logic                 op_sub;

   assign calc_ok_c = ({1'b0, bus.calc_mode} < MODE_LIMIT);
   // A write is dropped for an absent mode or for the mode currently being calculated
   assign wr_drop_c = ({1'b0, bus.wr_mode} >= MODE_LIMIT) ||
                      ((state != IDLE) && (bus.wr_mode == mode_q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_c   = 1'b0;
      commit_c  = 1'b0;
      case (state)
         IDLE: if (bus.calc_req && calc_ok_c) begin
                  state_nxt = CALC;
                  start_c   = 1'b1;
               end
         CALC: if (step == LAST_STEP) state_nxt = PEND;
         PEND: if (bus.frame_start) begin
                  state_nxt = IDLE;
                  commit_c  = 1'b1;
               end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_FIELDS; i++) fld[i] = bank[mode_q][i];
   end

   assign il_c = fld[F_FLAGS][0];

   // Step schedule for the shared ALU; later steps reuse earlier shadow results
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      op_sub = 1'b0;
      case (int'(step))
         S_VACT:        begin op_a = fld[F_LINES_F0]; op_b = il_c ? fld[F_LINES_F1] : '0; end
         S_F2_V_START:  begin op_a = sh[S_VACT];      op_b = il_c ? fld[F_V1_BLANK] : '0; end
         S_V_TOTAL:     begin op_a = sh[S_F2_V_START]; op_b = fld[F_V_BLANK]; end
         S_V_TOTAL_M1:  begin op_a = sh[S_V_TOTAL];   op_b = WIDTH'(1); op_sub = 1'b1; end
         S_AP_END:      begin op_a = sh[S_V_TOTAL];   op_b = fld[F_AP_LINE]; op_sub = 1'b1; end
         S_H_TOTAL:     begin op_a = fld[F_SAMPLES];  op_b = fld[F_H_BLANK]; end
         S_H_TOTAL_M1:  begin op_a = sh[S_H_TOTAL];   op_b = WIDTH'(1); op_sub = 1'b1; end
         S_SAV:         begin op_a = fld[F_H_BLANK];  op_b = WIDTH'(fld[F_TRS][3:0]); op_sub = 1'b1; end
         S_HS_START:    begin op_a = fld[F_H_FP];     op_b = '0; end
         S_HS_END:      begin op_a = fld[F_H_FP];     op_b = fld[F_H_SYNC]; end
         S_F1_V_START:  begin op_a = fld[F_V1_RISE];  op_b = fld[F_AP_LINE]; op_sub = 1'b1; end
         S_F1_V_END:    begin op_a = sh[S_F1_V_START]; op_b = fld[F_V1_BLANK]; end
         S_F2_VS_START: begin op_a = sh[S_F2_V_START]; op_b = fld[F_V_FP]; end
         S_F2_VS_END:   begin op_a = sh[S_F2_VS_START]; op_b = fld[F_V_SYNC]; end
         S_F1_VS_START: begin op_a = sh[S_F1_V_START]; op_b = fld[F_V1_FP]; end
         S_F1_VS_END:   begin op_a = sh[S_F1_VS_START]; op_b = fld[F_V1_SYNC]; end
         default:       begin op_a = '0; op_b = '0; end
      endcase
      alu_c = op_sub ? (op_a - op_b) : (op_a + op_b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int m = 0; m < NUM_MODES; m++)
            for (int f = 0; f < NUM_FIELDS; f++) bank[m][f] <= '0;
         bus.wr_err <= 1'b0;
      end else begin
         bus.wr_err <= bus.wr_en && wr_drop_c;
         if (bus.wr_en && !wr_drop_c) bank[bus.wr_mode][bus.wr_addr] <= bus.wr_data;
      end
   end

   // Calculation sequencing and shadow capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_FIELDS; i++) sh[i] <= '0;
         sh_il         <= 1'b0;
         sh_ser        <= 1'b0;
         sh_h_blank    <= '0;
         step          <= '0;
         mode_q        <= '0;
         bus.calc_busy <= 1'b0;
         bus.commit    <= 1'b0;
      end else begin
         bus.calc_busy <= (state_nxt != IDLE);
         bus.commit    <= commit_c;
         if (start_c) begin
            mode_q <= bus.calc_mode;
            step   <= '0;
         end else if (state == CALC) begin
            step <= step + STEP_BITS'(1);
         end
         if (state == CALC) begin
            sh[step] <= alu_c;
            if (step == '0) begin
               sh_il      <= fld[F_FLAGS][0];
               sh_ser     <= fld[F_FLAGS][1];
               sh_h_blank <= fld[F_H_BLANK];
            end
         end
      end
   end

   // Live timing set: changes only on the commit edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.active_mode       <= '0;
         bus.interlaced        <= 1'b0;
         bus.serial_output     <= 1'b0;
         bus.h_total_minus_one <= '0;
         bus.v_total_minus_one <= '0;
         bus.ap_line_end       <= '0;
         bus.h_blank           <= '0;
         bus.sav               <= '0;
         bus.h_sync_start      <= '0;
         bus.h_sync_end        <= '0;
         bus.f2_v_start        <= '0;
         bus.f1_v_start        <= '0;
         bus.f1_v_end          <= '0;
         bus.f2_v_sync_start   <= '0;
         bus.f2_v_sync_end     <= '0;
         bus.f1_v_sync_start   <= '0;
         bus.f1_v_sync_end     <= '0;
      end else if (commit_c) begin
         bus.active_mode       <= mode_q;
         bus.interlaced        <= sh_il;
         bus.serial_output     <= sh_ser;
         bus.h_total_minus_one <= sh[S_H_TOTAL_M1];
         bus.v_total_minus_one <= sh[S_V_TOTAL_M1];
         bus.ap_line_end       <= sh[S_AP_END];
         bus.h_blank           <= sh_h_blank;
         bus.sav               <= sh[S_SAV];
         bus.h_sync_start      <= sh[S_HS_START];
         bus.h_sync_end        <= sh[S_HS_END];
         bus.f2_v_start        <= sh[S_F2_V_START];
         bus.f1_v_start        <= sh[S_F1_V_START];
         bus.f1_v_end          <= sh[S_F1_V_END];
         bus.f2_v_sync_start   <= sh[S_F2_VS_START];
         bus.f2_v_sync_end     <= sh[S_F2_VS_END];
         bus.f1_v_sync_start   <= sh[S_F1_VS_START];
         bus.f1_v_sync_end     <= sh[S_F1_VS_END];
      end
   end

endmodule

// File: tb/tb_alt_vipitc_mode_bank_calc.sv
// Self-checking bench for alt_vipitc_mode_bank_calc: directed mode scenarios plus random
// descriptors compared against an arithmetic model of the timing rules.
module tb_alt_vipitc_mode_bank_calc;
   localparam int unsigned W  = 16;
   localparam int unsigned NM = 3;
   localparam int unsigned MB = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alt_vipitc_mode_bank_calc_if #(.WIDTH(W), .MODE_BITS(MB)) bus ();

   alt_vipitc_mode_bank_calc #(.WIDTH(W), .NUM_MODES(NM), .MODE_BITS(MB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc = 0;
   int cur_mode = 0;

   logic [15:0] mb [NM][16];
   logic [15:0] e  [14];
   logic        e_il, e_ser;
   logic [1:0]  e_mode;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected live set straight from the timing formulas, modulo 2^16
   task automatic model_commit(input int m);
      int sc, lc0, lc1, hfp, hsl, hb, vfp, vsl, vb, v1fp, v1sl, v1b, apl, v1re, trs;
      int vact, vb1, vt, f1s;
      bit il;
      il = mb[m][0][0];
      sc = int'(mb[m][1]);   lc0 = int'(mb[m][2]);   lc1 = int'(mb[m][3]);
      hfp = int'(mb[m][4]);  hsl = int'(mb[m][5]);   hb = int'(mb[m][6]);
      vfp = int'(mb[m][7]);  vsl = int'(mb[m][8]);   vb = int'(mb[m][9]);
      v1fp = int'(mb[m][10]); v1sl = int'(mb[m][11]); v1b = int'(mb[m][12]);
      apl = int'(mb[m][13]); v1re = int'(mb[m][14]); trs = int'(mb[m][15]) % 16;
      vact = lc0 + (il ? lc1 : 0);
      vb1  = il ? v1b : 0;
      vt   = vact + vb1 + vb;
      f1s  = v1re - apl;
      e[0]  = 16'(sc + hb - 1);
      e[1]  = 16'(vt - 1);
      e[2]  = 16'(vt - apl);
      e[3]  = 16'(hb);
      e[4]  = 16'(hb - trs);
      e[5]  = 16'(hfp);
      e[6]  = 16'(hfp + hsl);
      e[7]  = 16'(vact + vb1);
      e[8]  = 16'(f1s);
      e[9]  = 16'(f1s + v1b);
      e[10] = 16'(vact + vb1 + vfp);
      e[11] = 16'(vact + vb1 + vfp + vsl);
      e[12] = 16'(f1s + v1fp);
      e[13] = 16'(f1s + v1fp + v1sl);
      e_il   = il;
      e_ser  = mb[m][0][1];
      e_mode = 2'(m);
   endtask

   task automatic check_live(input string t);
      chk({t, ".active_mode"},   32'(bus.active_mode),       32'(e_mode));
      chk({t, ".interlaced"},    32'(bus.interlaced),        32'(e_il));
      chk({t, ".serial_output"}, 32'(bus.serial_output),     32'(e_ser));
      chk({t, ".h_total_m1"},    32'(bus.h_total_minus_one), 32'(e[0]));
      chk({t, ".v_total_m1"},    32'(bus.v_total_minus_one), 32'(e[1]));
      chk({t, ".ap_line_end"},   32'(bus.ap_line_end),       32'(e[2]));
      chk({t, ".h_blank"},       32'(bus.h_blank),           32'(e[3]));
      chk({t, ".sav"},           32'(bus.sav),               32'(e[4]));
      chk({t, ".h_sync_start"},  32'(bus.h_sync_start),      32'(e[5]));
      chk({t, ".h_sync_end"},    32'(bus.h_sync_end),        32'(e[6]));
      chk({t, ".f2_v_start"},    32'(bus.f2_v_start),        32'(e[7]));
      chk({t, ".f1_v_start"},    32'(bus.f1_v_start),        32'(e[8]));
      chk({t, ".f1_v_end"},      32'(bus.f1_v_end),          32'(e[9]));
      chk({t, ".f2_vs_start"},   32'(bus.f2_v_sync_start),   32'(e[10]));
      chk({t, ".f2_vs_end"},     32'(bus.f2_v_sync_end),     32'(e[11]));
      chk({t, ".f1_vs_start"},   32'(bus.f1_v_sync_start),   32'(e[12]));
      chk({t, ".f1_vs_end"},     32'(bus.f1_v_sync_end),     32'(e[13]));
   endtask

   task automatic wr(input int m, input int a, input int d, input bit exp_err);
      bus.wr_en   = 1'b1;
      bus.wr_mode = 2'(m);
      bus.wr_addr = 4'(a);
      bus.wr_data = 16'(d);
      tick();
      bus.wr_en = 1'b0;
      chk("wr_err", 32'(bus.wr_err), 32'(exp_err));
      if (!exp_err) mb[m][a] = 16'(d);
   endtask

   task automatic wr_fields(input int m, input int v[16]);
      for (int a = 0; a < 16; a++) wr(m, a, v[a], 1'b0);
   endtask

   task automatic start_calc(input int m);
      bus.calc_req  = 1'b1;
      bus.calc_mode = 2'(m);
      tick();
      bus.calc_req = 1'b0;
      start_cyc = cyc;
      cur_mode  = m;
      chk("calc_busy_start", 32'(bus.calc_busy), 32'd1);
   endtask

   // Run to PEND while checking that nothing goes live early
   task automatic wait_pend();
      while (cyc - start_cyc < 16) begin
         chk("early_commit", 32'(bus.commit), 32'd0);
         chk("held_h_total", 32'(bus.h_total_minus_one), 32'(e[0]));
         tick();
      end
      chk("busy_in_pend", 32'(bus.calc_busy), 32'd1);
   endtask

   task automatic fire(input string t);
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      model_commit(cur_mode);
      chk({t, ".commit"}, 32'(bus.commit), 32'd1);
      check_live(t);
      tick();
      chk({t, ".commit_pulse"}, 32'(bus.commit), 32'd0);
      chk({t, ".busy_after"}, 32'(bus.calc_busy), 32'd0);
   endtask

   initial begin
      int f720[16];
      int fint[16];
      int frnd[16];
      int busy_cnt;
      f720 = '{0, 1280, 720, 0, 110, 40, 370, 5, 5, 30, 0, 0, 0, 26, 0, 4};
      fint = '{1, 1920, 540, 540, 88, 44, 280, 2, 5, 22, 2, 5, 23, 21, 564, 4};

      bus.wr_en = 1'b0; bus.wr_mode = '0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.calc_req = 1'b0; bus.calc_mode = '0; bus.frame_start = 1'b0;
      for (int m = 0; m < NM; m++) for (int a = 0; a < 16; a++) mb[m][a] = '0;
      for (int i = 0; i < 14; i++) e[i] = '0;
      e_il = 1'b0; e_ser = 1'b0; e_mode = '0;

      // Reset state
      repeat (3) tick();
      check_live("reset");
      chk("reset.commit", 32'(bus.commit), 32'd0);
      chk("reset.wr_err", 32'(bus.wr_err), 32'd0);
      chk("reset.busy",   32'(bus.calc_busy), 32'd0);
      rst = 1'b0;
      tick();

      // 720p progressive on mode 1, frame_start 20 cycles after the request
      wr_fields(1, f720);
      start_calc(1);
      repeat (20) begin
         chk("t1_no_commit", 32'(bus.commit), 32'd0);
         tick();
      end
      fire("t1");
      chk("t1.htm1_const", 32'(bus.h_total_minus_one), 32'd1649);
      chk("t1.vtm1_const", 32'(bus.v_total_minus_one), 32'd749);
      chk("t1.sav_const",  32'(bus.sav),               32'd366);
      chk("t1.hse_const",  32'(bus.h_sync_end),        32'd150);
      chk("t1.f2vs_const", 32'(bus.f2_v_start),        32'd720);
      chk("t1.f2vss_const", 32'(bus.f2_v_sync_start),  32'd725);
      chk("t1.f2vse_const", 32'(bus.f2_v_sync_end),    32'd730);
      chk("t1.ape_const",  32'(bus.ap_line_end),       32'd724);
      chk("t1.mode_const", 32'(bus.active_mode),       32'd1);

      // Interlaced on mode 2; frame_start in the last CALC cycle must not commit
      wr_fields(2, fint);
      start_calc(2);
      while (cyc - start_cyc < 15) tick();
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      chk("t2.last_calc_commit", 32'(bus.commit), 32'd0);
      chk("t2.last_calc_busy",   32'(bus.calc_busy), 32'd1);
      chk("t2.held_mode",        32'(bus.active_mode), 32'd1);
      repeat (3) tick();
      chk("t2.still_pending", 32'(bus.commit), 32'd0);
      fire("t2");
      chk("t2.vtm1_const",  32'(bus.v_total_minus_one), 32'd1124);
      chk("t2.f2vs_const",  32'(bus.f2_v_start),        32'd1103);
      chk("t2.f1vs_const",  32'(bus.f1_v_start),        32'd543);
      chk("t2.f1ve_const",  32'(bus.f1_v_end),          32'd566);

      // frame_start held high through CALC: busy 16 CALC cycles + one PEND cycle
      for (int a = 0; a < 16; a++) frnd[a] = (a == 0) ? int'($urandom_range(0, 3)) : int'($urandom % 4096);
      wr_fields(0, frnd);
      bus.frame_start = 1'b1;
      start_calc(0);
      busy_cnt = 0;
      while (bus.calc_busy === 1'b1 && busy_cnt < 40) begin
         busy_cnt++;
         chk("t3_no_commit", 32'(bus.commit), 32'd0);
         chk("t3_held_mode", 32'(bus.active_mode), 32'd2);
         tick();
      end
      bus.frame_start = 1'b0;
      model_commit(0);
      chk("t3.busy_cycles", 32'(busy_cnt), 32'd17);
      chk("t3.commit", 32'(bus.commit), 32'd1);
      check_live("t3");
      tick();

      // Writes while calculating mode 0
      start_calc(0);
      wr(0, 1, int'(mb[0][1]) + 100, 1'b1);
      wr(1, 6, 123, 1'b0);
      wr(3, 0, 1, 1'b1);
      tick();
      chk("t4.wr_err_clear", 32'(bus.wr_err), 32'd0);
      wait_pend();
      fire("t4a");
      start_calc(1);
      wait_pend();
      fire("t4b");

      // calc_req while busy is ignored
      start_calc(1);
      repeat (3) tick();
      bus.calc_req = 1'b1; bus.calc_mode = 2'd2;
      repeat (3) tick();
      bus.calc_req = 1'b0;
      wait_pend();
      fire("t5a");
      // calc_req with an absent mode in IDLE is ignored
      bus.calc_req = 1'b1; bus.calc_mode = 2'd3;
      tick();
      bus.calc_req = 1'b0;
      chk("t5.bad_mode_busy", 32'(bus.calc_busy), 32'd0);
      repeat (3) begin
         bus.frame_start = 1'b1;
         tick();
         bus.frame_start = 1'b0;
         chk("t5.bad_mode_commit", 32'(bus.commit), 32'd0);
         tick();
      end
      check_live("t5b");

      // Reset during PEND discards everything
      start_calc(2);
      wait_pend();
      rst = 1'b1;
      #1;
      for (int m = 0; m < NM; m++) for (int a = 0; a < 16; a++) mb[m][a] = '0;
      for (int i = 0; i < 14; i++) e[i] = '0;
      e_il = 1'b0; e_ser = 1'b0; e_mode = '0;
      check_live("t6_rst");
      chk("t6.busy", 32'(bus.calc_busy), 32'd0);
      tick();
      rst = 1'b0;
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      chk("t6.no_commit", 32'(bus.commit), 32'd0);
      check_live("t6_post");
      wr(0, 15, 4, 1'b0);
      start_calc(0);
      wait_pend();
      fire("t6");
      chk("t6.sav_wrap", 32'(bus.sav), 32'h0000FFFC);

      // Random descriptors
      for (int it = 0; it < 8; it++) begin
         int m;
         m = int'($urandom_range(0, NM - 1));
         for (int a = 0; a < 16; a++) frnd[a] = (a == 0) ? int'($urandom_range(0, 3)) : int'($urandom % 65536);
         wr_fields(m, frnd);
         start_calc(m);
         wait_pend();
         repeat ($urandom_range(0, 4)) tick();
         fire("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
